mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter sharing the single physical-memory Wishbone port between the L1 instruction cache and the L1 data cache.
- Each cache presents a line-granular master interface: 128-bit line, 12-bit line address (ADR = byte address [15:4]), 16-bit SEL.
- The arbiter grants one cache at a time and muxes that cache's signals onto the memory port. The non-granted cache is held off with RTY.
- Round-robin grant order prevents starvation. Per-requester grant counters are exposed for performance monitoring.

Parameters:
- ADR_W, 12, line address width
- DAT_W, 128, line data width
- SEL_W, 16, byte-select width
- CNT_W, 16, grant counter width

Ports:
- clk  in  1  single clock; every port in this block is synchronous to clk
- rst_n  in  1  reset, synchronous, active-low
- i_cyc, i_stb, i_we  in  1 each  I-cache master cycle / strobe / write enable
- i_adr  in  ADR_W  I-cache line address
- i_sel  in  SEL_W  I-cache byte selects
- i_dat_m  in  DAT_W  I-cache write data
- i_dat_s  out  DAT_W  read data returned to I-cache
- i_ack, i_rty  out  1 each  I-cache acknowledge / retry
- d_cyc, d_stb, d_we, d_adr, d_sel, d_dat_m, d_dat_s, d_ack, d_rty  same widths and directions as the i_* ports  D-cache master
- m_cyc, m_stb, m_we  out  1 each  to physical memory
- m_adr  out  ADR_W  to physical memory
- m_sel  out  SEL_W  to physical memory
- m_dat_m  out  DAT_W  write data to physical memory
- m_dat_s  in  DAT_W  read data from physical memory
- m_ack, m_rty  in  1 each  from physical memory
- i_grant_cnt, d_grant_cnt  out  CNT_W  completed transactions per requester

Behaviour:
- Request definition: req_i = i_cyc & i_stb; req_d = d_cyc & d_stb.
- FSM states: IDLE, GNT_I, GNT_D. The state is registered. Additionally:
  - last_gnt: 1 bit, records the last completed grant.
  - Grant counters: registered.
- Reset (rst_n = 0 at a clk edge): state = IDLE, last_gnt = I, both counters = 0.
- Reset applies mid-transaction: the grant is abandoned and no counter increments.
- Output values whenever not granted, including reset:
  - m_cyc, m_stb, m_we = 0.
  - m_adr, m_sel, m_dat_m = 0.
  - i_ack, d_ack = 0.
- IDLE transitions:
  - Only req_i → GNT_I.
  - Only req_d → GNT_D.
  - Both → the requester not equal to last_gnt.
  - Neither → stay in IDLE.
- GNT_x outputs:
  - m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m are driven combinationally from master x.
  - x_dat_s = m_dat_s.
  - x_ack = m_ack & req_x.
  - x_rty = m_rty.
- Non-granted master y (any state, including IDLE):
  - y_ack = 0.
  - y_rty = req_y.
  - y_dat_s = m_dat_s (don't-care, unqualified).
- Grant release: in GNT_x, a cycle where m_ack = 1 and req_x = 1 completes the transaction. On the next clk edge:
  - state → IDLE,
  - last_gnt = x,
  - x_grant_cnt increments by 1, wrapping modulo 2^CNT_W.
- Abandoned transaction: in GNT_x, if req_x drops without an ack, state → IDLE next edge; last_gnt and the counter are unchanged.
- Bubble cycle: exactly one IDLE cycle always separates consecutive grants. m_cyc is therefore low for at least one cycle between transactions.
- Latency:
  - A request first asserted in cycle t, with the arbiter in IDLE and winning arbitration, drives m_cyc in cycle t+1.
  - m_ack is passed through to the winner in the same cycle (zero added latency).
- Memory retry: m_rty asserted while granted does not release the grant. The granted master keeps its request and the arbiter keeps driving memory.
- Simultaneous requests from reset: the D-cache wins first (last_gnt = I at reset).
- Write-back followed by allocate from the same master: these are two separate transactions, each arbitrated. The other cache can interleave between them.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with both requesting → m_cyc = 0, i_rty = d_rty = 1, i_ack = d_ack = 0, counters = 0.
- Single I-cache read: i_adr = 12'h0A3; memory acks 4 cycles after m_stb with m_dat_s = 128'hDEAD…BEEF → m_adr = 12'h0A3 from cycle t+1, i_ack pulses once with i_dat_s = that data, i_grant_cnt = 1, state IDLE one cycle later.
- Both request at cycle 0 after reset → D granted first; d_ack completes; one IDLE cycle; then I granted; I ack; counters = 1/1; i_rty = 1 throughout the D transaction.
- D-cache dirty write-back (d_we = 1, d_dat_m = 128'h1234…) followed immediately by a read, while the I-cache requests continuously → order D(write), I, D(read); m_we = 1 only during the D-write grant.
- m_rty pulses for 2 cycles during a D grant, then m_ack → grant held across the retry, d_rty follows m_rty, single completion, d_grant_cnt increments by 1.
- rst_n driven low mid I-grant before m_ack → next cycle m_cyc = 0, i_grant_cnt unchanged (0). Preload counter to 16'hFFFF and complete a transaction → wraps to 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single physical-memory Wishbone port between the L1 instruction
// cache (i_*) and the L1 data cache (d_*). One cache is granted at a time and
// its master signals are muxed combinationally onto the memory port (m_*).
// The cache that is not granted sees RTY for as long as it requests.
// When both caches request at once, the grant goes to the cache that did not
// complete the last transaction. Exactly one IDLE cycle always separates two
// grants.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   i_cyc/i_stb/i_we/i_adr/
//   i_sel/i_dat_m               I-cache master request
//   i_dat_s/i_ack/i_rty         responses returned to the I-cache
//   d_*                         same set of signals for the D-cache
//   m_cyc/m_stb/m_we/m_adr/
//   m_sel/m_dat_m               request driven to physical memory
//   m_dat_s/m_ack/m_rty         responses from physical memory
//   i_grant_cnt/d_grant_cnt     completed transactions per cache (wrapping)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADR_W = 12,
  parameter int DAT_W = 128,
  parameter int SEL_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // I-cache master
  input  logic             i_cyc,
  input  logic             i_stb,
  input  logic             i_we,
  input  logic [ADR_W-1:0] i_adr,
  input  logic [SEL_W-1:0] i_sel,
  input  logic [DAT_W-1:0] i_dat_m,
  output logic [DAT_W-1:0] i_dat_s,
  output logic             i_ack,
  output logic             i_rty,
  // D-cache master
  input  logic             d_cyc,
  input  logic             d_stb,
  input  logic             d_we,
  input  logic [ADR_W-1:0] d_adr,
  input  logic [SEL_W-1:0] d_sel,
  input  logic [DAT_W-1:0] d_dat_m,
  output logic [DAT_W-1:0] d_dat_s,
  output logic             d_ack,
  output logic             d_rty,
  // physical memory port
  output logic             m_cyc,
  output logic             m_stb,
  output logic             m_we,
  output logic [ADR_W-1:0] m_adr,
  output logic [SEL_W-1:0] m_sel,
  output logic [DAT_W-1:0] m_dat_m,
  input  logic [DAT_W-1:0] m_dat_s,
  input  logic             m_ack,
  input  logic             m_rty,
  // performance counters
  output logic [CNT_W-1:0] i_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  // last_gnt_r encoding: which cache completed most recently
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic             last_gnt_r;
  logic [CNT_W-1:0] i_cnt_r;
  logic [CNT_W-1:0] d_cnt_r;

  logic req_i_s;
  logic req_d_s;
  logic done_i_s;
  logic done_d_s;

  assign req_i_s  = i_cyc & i_stb;
  assign req_d_s  = d_cyc & d_stb;
  // Completion: memory acks while the granted master still holds its request.
  assign done_i_s = (state_r == GNT_I) & req_i_s & m_ack;
  assign done_d_s = (state_r == GNT_D) & req_d_s & m_ack;

  assign i_grant_cnt = i_cnt_r;
  assign d_grant_cnt = d_cnt_r;

  // State, last-grant and grant-counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_gnt_r <= LAST_I;
      i_cnt_r    <= CNT_ZERO;
      d_cnt_r    <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      if (done_i_s) begin
        last_gnt_r <= LAST_I;
        i_cnt_r    <= i_cnt_r + CNT_ONE;
      end else if (done_d_s) begin
        last_gnt_r <= LAST_D;
        d_cnt_r    <= d_cnt_r + CNT_ONE;
      end else begin
        last_gnt_r <= last_gnt_r;
      end
    end
  end

  // Next-state logic: round-robin arbitration from IDLE, release to IDLE on
  // completion or on the granted master dropping its request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_i_s && req_d_s) begin
          state_nxt_s = (last_gnt_r == LAST_I) ? GNT_D : GNT_I;
        end else if (req_i_s) begin
          state_nxt_s = GNT_I;
        end else if (req_d_s) begin
          state_nxt_s = GNT_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_I: begin
        if (!req_i_s || m_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GNT_I;
        end
      end
      GNT_D: begin
        if (!req_d_s || m_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GNT_D;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output mux: memory port follows the granted master; the other master is
  // held off with RTY whenever it requests. Read data is broadcast unqualified.
  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = {ADR_W{1'b0}};
    m_sel   = {SEL_W{1'b0}};
    m_dat_m = {DAT_W{1'b0}};
    i_dat_s = m_dat_s;
    d_dat_s = m_dat_s;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    i_rty   = req_i_s;
    d_rty   = req_d_s;
    case (state_r)
      GNT_I: begin
        m_cyc   = i_cyc;
        m_stb   = i_stb;
        m_we    = i_we;
        m_adr   = i_adr;
        m_sel   = i_sel;
        m_dat_m = i_dat_m;
        i_ack   = m_ack & req_i_s;
        i_rty   = m_rty;
      end
      GNT_D: begin
        m_cyc   = d_cyc;
        m_stb   = d_stb;
        m_we    = d_we;
        m_adr   = d_adr;
        m_sel   = d_sel;
        m_dat_m = d_dat_m;
        d_ack   = m_ack & req_d_s;
        d_rty   = m_rty;
      end
      IDLE: begin
        m_cyc = 1'b0;
      end
      default: begin
        m_cyc = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A table of per-cycle vectors covers
// round-robin arbitration, the bubble cycle and write-back/allocate
// interleaving; hand-written sequences cover reset, a single line read with
// memory latency, memory retry, reset mid-grant and counter wrap (the latter
// on a second instance with a 3-bit counter that shares all inputs).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADR_W = 12;
  localparam int DAT_W = 128;
  localparam int SEL_W = 16;
  localparam int CNT_W = 16;

  localparam logic [SEL_W-1:0] I_SEL = 16'h00FF;
  localparam logic [SEL_W-1:0] D_SEL = 16'hFF00;
  localparam logic [DAT_W-1:0] I_DAT = 128'hAAAA_0000_1111_2222_3333_4444_5555_AAAA;
  localparam logic [DAT_W-1:0] D_DAT = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;
  localparam logic [DAT_W-1:0] M_DAT = 128'hDEAD_0123_4567_89AB_CDEF_0123_4567_BEEF;

  logic             clk;
  logic             rst_n;
  logic             i_cyc, i_stb, i_we;
  logic [ADR_W-1:0] i_adr;
  logic [SEL_W-1:0] i_sel;
  logic [DAT_W-1:0] i_dat_m, i_dat_s;
  logic             i_ack, i_rty;
  logic             d_cyc, d_stb, d_we;
  logic [ADR_W-1:0] d_adr;
  logic [SEL_W-1:0] d_sel;
  logic [DAT_W-1:0] d_dat_m, d_dat_s;
  logic             d_ack, d_rty;
  logic             m_cyc, m_stb, m_we;
  logic [ADR_W-1:0] m_adr;
  logic [SEL_W-1:0] m_sel;
  logic [DAT_W-1:0] m_dat_m, m_dat_s;
  logic             m_ack, m_rty;
  logic [CNT_W-1:0] i_grant_cnt, d_grant_cnt;

  // outputs of the narrow-counter instance
  logic [DAT_W-1:0] w_i_dat_s, w_d_dat_s;
  logic             w_i_ack, w_i_rty, w_d_ack, w_d_rty;
  logic             w_m_cyc, w_m_stb, w_m_we;
  logic [ADR_W-1:0] w_m_adr;
  logic [SEL_W-1:0] w_m_sel;
  logic [DAT_W-1:0] w_m_dat_m;
  logic [2:0]       w_i_grant_cnt, w_d_grant_cnt;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_sel(i_sel),
    .i_dat_m(i_dat_m), .i_dat_s(i_dat_s), .i_ack(i_ack), .i_rty(i_rty),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_sel(d_sel),
    .d_dat_m(d_dat_m), .d_dat_s(d_dat_s), .d_ack(d_ack), .d_rty(d_rty),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_m(m_dat_m), .m_dat_s(m_dat_s), .m_ack(m_ack), .m_rty(m_rty),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  mem_port_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_sel(i_sel),
    .i_dat_m(i_dat_m), .i_dat_s(w_i_dat_s), .i_ack(w_i_ack), .i_rty(w_i_rty),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_sel(d_sel),
    .d_dat_m(d_dat_m), .d_dat_s(w_d_dat_s), .d_ack(w_d_ack), .d_rty(w_d_rty),
    .m_cyc(w_m_cyc), .m_stb(w_m_stb), .m_we(w_m_we), .m_adr(w_m_adr), .m_sel(w_m_sel),
    .m_dat_m(w_m_dat_m), .m_dat_s(m_dat_s), .m_ack(m_ack), .m_rty(m_rty),
    .i_grant_cnt(w_i_grant_cnt), .d_grant_cnt(w_d_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row per clock cycle: inputs for that cycle and the outputs
  // expected in that same cycle. gnt: 0 = none, 1 = I-cache, 2 = D-cache.
  typedef struct {
    logic             ir, iw;
    logic [ADR_W-1:0] ia;
    logic             dr, dw;
    logic [ADR_W-1:0] da;
    logic             ack, rty;
    logic [1:0]       gnt;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic             iack, irty, dack, drty;
    logic [CNT_W-1:0] icnt, dcnt;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(
    input logic ir, input logic iw, input logic [ADR_W-1:0] ia,
    input logic dr, input logic dw, input logic [ADR_W-1:0] da,
    input logic ack, input logic rty,
    input logic [1:0] gnt, input logic we, input logic [ADR_W-1:0] adr,
    input logic iack, input logic irty, input logic dack, input logic drty,
    input logic [CNT_W-1:0] icnt, input logic [CNT_W-1:0] dcnt);
    vec_t v;
    v.ir = ir; v.iw = iw; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.ack = ack; v.rty = rty; v.gnt = gnt; v.we = we; v.adr = adr;
    v.iack = iack; v.irty = irty; v.dack = dack; v.drty = drty;
    v.icnt = icnt; v.dcnt = dcnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DAT_W-1:0] act, input logic [DAT_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // advance to just after the next rising edge, where inputs are driven
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after driving inputs
  task automatic settle();
    #2;
  endtask

  initial begin
    logic [SEL_W-1:0] exp_sel;
    logic [DAT_W-1:0] exp_dat;
    int ack_seen;

    // row: ir iw ia       dr dw da       ack rty gnt we adr    iack irty dack drty icnt dcnt
    tbl[0]  = mk(1'b1,1'b0,12'h011, 1'b1,1'b0,12'h022, 1'b0,1'b0, 2'd0,1'b0,12'h000, 1'b0,1'b1,1'b0,1'b1, 16'd0,16'd0);
    tbl[1]  = mk(1'b1,1'b0,12'h011, 1'b1,1'b0,12'h022, 1'b0,1'b0, 2'd2,1'b0,12'h022, 1'b0,1'b1,1'b0,1'b0, 16'd0,16'd0);
    tbl[2]  = mk(1'b1,1'b0,12'h011, 1'b1,1'b0,12'h022, 1'b1,1'b0, 2'd2,1'b0,12'h022, 1'b0,1'b1,1'b1,1'b0, 16'd0,16'd0);
    tbl[3]  = mk(1'b1,1'b0,12'h011, 1'b0,1'b0,12'h022, 1'b0,1'b0, 2'd0,1'b0,12'h000, 1'b0,1'b1,1'b0,1'b0, 16'd0,16'd1);
    tbl[4]  = mk(1'b1,1'b0,12'h011, 1'b0,1'b0,12'h022, 1'b0,1'b0, 2'd1,1'b0,12'h011, 1'b0,1'b0,1'b0,1'b0, 16'd0,16'd1);
    tbl[5]  = mk(1'b1,1'b0,12'h011, 1'b0,1'b0,12'h022, 1'b1,1'b0, 2'd1,1'b0,12'h011, 1'b1,1'b0,1'b0,1'b0, 16'd0,16'd1);
    tbl[6]  = mk(1'b0,1'b0,12'h011, 1'b0,1'b0,12'h022, 1'b0,1'b0, 2'd0,1'b0,12'h000, 1'b0,1'b0,1'b0,1'b0, 16'd1,16'd1);
    // D write-back, then D read allocate, with the I-cache requesting
    tbl[7]  = mk(1'b1,1'b0,12'h011, 1'b1,1'b1,12'h0F0, 1'b0,1'b0, 2'd0,1'b0,12'h000, 1'b0,1'b1,1'b0,1'b1, 16'd1,16'd1);
    tbl[8]  = mk(1'b1,1'b0,12'h011, 1'b1,1'b1,12'h0F0, 1'b0,1'b0, 2'd2,1'b1,12'h0F0, 1'b0,1'b1,1'b0,1'b0, 16'd1,16'd1);
    tbl[9]  = mk(1'b1,1'b0,12'h011, 1'b1,1'b1,12'h0F0, 1'b1,1'b0, 2'd2,1'b1,12'h0F0, 1'b0,1'b1,1'b1,1'b0, 16'd1,16'd1);
    tbl[10] = mk(1'b1,1'b0,12'h011, 1'b1,1'b0,12'h0F0, 1'b0,1'b0, 2'd0,1'b0,12'h000, 1'b0,1'b1,1'b0,1'b1, 16'd1,16'd2);
    tbl[11] = mk(1'b1,1'b0,12'h011, 1'b1,1'b0,12'h0F0, 1'b0,1'b0, 2'd1,1'b0,12'h011, 1'b0,1'b0,1'b0,1'b1, 16'd1,16'd2);
    tbl[12] = mk(1'b1,1'b0,12'h011, 1'b1,1'b0,12'h0F0, 1'b1,1'b0, 2'd1,1'b0,12'h011, 1'b1,1'b0,1'b0,1'b1, 16'd1,16'd2);
    tbl[13] = mk(1'b0,1'b0,12'h011, 1'b1,1'b0,12'h0F0, 1'b0,1'b0, 2'd0,1'b0,12'h000, 1'b0,1'b0,1'b0,1'b1, 16'd2,16'd2);
    tbl[14] = mk(1'b0,1'b0,12'h011, 1'b1,1'b0,12'h0F0, 1'b0,1'b0, 2'd2,1'b0,12'h0F0, 1'b0,1'b0,1'b0,1'b0, 16'd2,16'd2);
    tbl[15] = mk(1'b0,1'b0,12'h011, 1'b1,1'b0,12'h0F0, 1'b1,1'b0, 2'd2,1'b0,12'h0F0, 1'b0,1'b0,1'b1,1'b0, 16'd2,16'd2);
    tbl[16] = mk(1'b0,1'b0,12'h011, 1'b0,1'b0,12'h0F0, 1'b0,1'b0, 2'd0,1'b0,12'h000, 1'b0,1'b0,1'b0,1'b0, 16'd2,16'd3);

    // reset held for 3 cycles with both caches requesting
    rst_n = 1'b0;
    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 12'h011; i_sel = I_SEL; i_dat_m = I_DAT;
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_adr = 12'h022; d_sel = D_SEL; d_dat_m = D_DAT;
    m_dat_s = M_DAT; m_ack = 1'b0; m_rty = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      settle();
      chk("reset_m_cyc", {127'd0, m_cyc}, 128'd0);
      chk("reset_i_rty", {127'd0, i_rty}, 128'd1);
      chk("reset_d_rty", {127'd0, d_rty}, 128'd1);
      chk("reset_acks", {126'd0, i_ack, d_ack}, 128'd0);
      chk("reset_m_adr", {116'd0, m_adr}, 128'd0);
      chk("reset_i_cnt", {112'd0, i_grant_cnt}, 128'd0);
      chk("reset_d_cnt", {112'd0, d_grant_cnt}, 128'd0);
    end

    // table-driven cycles
    for (int r = 0; r < 17; r++) begin
      step();
      rst_n  = 1'b1;
      i_cyc  = tbl[r].ir; i_stb = tbl[r].ir; i_we = tbl[r].iw; i_adr = tbl[r].ia;
      d_cyc  = tbl[r].dr; d_stb = tbl[r].dr; d_we = tbl[r].dw; d_adr = tbl[r].da;
      m_ack  = tbl[r].ack; m_rty = tbl[r].rty;
      settle();
      exp_sel = (tbl[r].gnt == 2'd1) ? I_SEL : (tbl[r].gnt == 2'd2) ? D_SEL : 16'h0000;
      exp_dat = (tbl[r].gnt == 2'd1) ? I_DAT : (tbl[r].gnt == 2'd2) ? D_DAT : 128'd0;
      chk($sformatf("row%0d_m_cyc", r), {127'd0, m_cyc}, {127'd0, (tbl[r].gnt != 2'd0)});
      chk($sformatf("row%0d_m_stb", r), {127'd0, m_stb}, {127'd0, (tbl[r].gnt != 2'd0)});
      chk($sformatf("row%0d_m_we", r), {127'd0, m_we}, {127'd0, tbl[r].we});
      chk($sformatf("row%0d_m_adr", r), {116'd0, m_adr}, {116'd0, tbl[r].adr});
      chk($sformatf("row%0d_m_sel", r), {112'd0, m_sel}, {112'd0, exp_sel});
      chk($sformatf("row%0d_m_dat_m", r), m_dat_m, exp_dat);
      chk($sformatf("row%0d_i_ack", r), {127'd0, i_ack}, {127'd0, tbl[r].iack});
      chk($sformatf("row%0d_i_rty", r), {127'd0, i_rty}, {127'd0, tbl[r].irty});
      chk($sformatf("row%0d_d_ack", r), {127'd0, d_ack}, {127'd0, tbl[r].dack});
      chk($sformatf("row%0d_d_rty", r), {127'd0, d_rty}, {127'd0, tbl[r].drty});
      chk($sformatf("row%0d_i_dat_s", r), i_dat_s, M_DAT);
      chk($sformatf("row%0d_i_cnt", r), {112'd0, i_grant_cnt}, {112'd0, tbl[r].icnt});
      chk($sformatf("row%0d_d_cnt", r), {112'd0, d_grant_cnt}, {112'd0, tbl[r].dcnt});
    end

    // single I-cache line read, memory acks 4 cycles after strobe
    step();
    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 12'h0A3; i_sel = 16'hFFFF;
    d_cyc = 1'b0; d_stb = 1'b0; m_ack = 1'b0; m_rty = 1'b0; m_dat_s = 128'd0;
    settle();
    chk("rd_t0_m_cyc", {127'd0, m_cyc}, 128'd0);
    ack_seen = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      settle();
      if (i_ack) ack_seen++;
      chk($sformatf("rd_t%0d_m_cyc", k), {127'd0, m_cyc}, 128'd1);
      chk($sformatf("rd_t%0d_m_adr", k), {116'd0, m_adr}, {116'd0, 12'h0A3});
      chk($sformatf("rd_t%0d_m_sel", k), {112'd0, m_sel}, {112'd0, 16'hFFFF});
    end
    step();
    m_ack = 1'b1; m_dat_s = M_DAT;
    settle();
    if (i_ack) ack_seen++;
    chk("rd_ack", {127'd0, i_ack}, 128'd1);
    chk("rd_i_dat_s", i_dat_s, M_DAT);
    step();
    m_ack = 1'b0; i_cyc = 1'b0; i_stb = 1'b0; i_sel = I_SEL;
    settle();
    if (i_ack) ack_seen++;
    chk("rd_done_m_cyc", {127'd0, m_cyc}, 128'd0);
    chk("rd_done_i_cnt", {112'd0, i_grant_cnt}, 128'd3);
    chk("rd_ack_pulses", ack_seen, 128'd1);

    // memory retry during a D grant, I-cache requesting throughout
    step();
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 12'h011;
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_adr = 12'h0F0;
    settle();
    chk("rty_idle_m_cyc", {127'd0, m_cyc}, 128'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      m_rty = 1'b1;
      settle();
      chk($sformatf("rty%0d_m_cyc", k), {127'd0, m_cyc}, 128'd1);
      chk($sformatf("rty%0d_m_adr", k), {116'd0, m_adr}, {116'd0, 12'h0F0});
      chk($sformatf("rty%0d_d_rty", k), {127'd0, d_rty}, 128'd1);
      chk($sformatf("rty%0d_i_rty", k), {127'd0, i_rty}, 128'd1);
      chk($sformatf("rty%0d_d_ack", k), {127'd0, d_ack}, 128'd0);
    end
    step();
    m_rty = 1'b0; m_ack = 1'b1;
    settle();
    chk("rty_ack_d_ack", {127'd0, d_ack}, 128'd1);
    chk("rty_ack_d_rty", {127'd0, d_rty}, 128'd0);
    chk("rty_ack_m_cyc", {127'd0, m_cyc}, 128'd1);
    step();
    m_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
    settle();
    chk("rty_done_m_cyc", {127'd0, m_cyc}, 128'd0);
    chk("rty_done_d_cnt", {112'd0, d_grant_cnt}, 128'd4);
    chk("rty_done_i_rty", {127'd0, i_rty}, 128'd1);

    // reset asserted during an I grant before memory acks
    step();
    settle();
    chk("mrst_gnt_m_cyc", {127'd0, m_cyc}, 128'd1);
    chk("mrst_gnt_m_adr", {116'd0, m_adr}, {116'd0, 12'h011});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    i_stb = 1'b0;  // cyc without stb is not a request
    settle();
    chk("mrst_m_cyc", {127'd0, m_cyc}, 128'd0);
    chk("mrst_i_cnt", {112'd0, i_grant_cnt}, 128'd0);
    chk("mrst_d_cnt", {112'd0, d_grant_cnt}, 128'd0);
    chk("nostb_i_rty", {127'd0, i_rty}, 128'd0);

    // back-to-back I transactions: bubble cycle between grants, and the
    // 3-bit counter instance wraps after 8 completions
    ack_seen = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      i_stb = 1'b1; m_ack = 1'b1;
      settle();
      if (i_ack) ack_seen++;
      chk($sformatf("b2b%0d_m_cyc", k), {127'd0, m_cyc}, {127'd0, (k % 2 == 1)});
    end
    step();
    i_cyc = 1'b0; i_stb = 1'b0; m_ack = 1'b0;
    settle();
    chk("b2b_acks", ack_seen, 128'd8);
    chk("b2b_i_cnt", {112'd0, i_grant_cnt}, 128'd8);
    chk("wrap_i_cnt", {125'd0, w_i_grant_cnt}, 128'd0);
    chk("wrap_d_cnt", {125'd0, w_d_grant_cnt}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
